ioctl_sdram_packer: RTL and testbench
=====================================

Name: ioctl_sdram_packer

Overview:
- Sits directly downstream of the SPI download receiver, on the clk_sys domain.
- Consumes its byte stream (ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout) and packs bytes into 16-bit SDRAM words with per-byte masks.
- Buffers the words in a small FIFO and presents them to the SDRAM controller's programming port through a request/ready handshake.
- Keeps the download "busy" indication asserted until every byte has reached SDRAM.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth in entries (default 4 entries).
- AW, 24, SDRAM word-address width; word address = ioctl_addr[AW:1].

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  high while a download is active.
- ioctl_wr  in  1  byte strobe; may stay high for several cycles per byte.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- prog_addr  out  AW  SDRAM word address.
- prog_data  out  16  word data; even byte in [7:0], odd byte in [15:8].
- prog_mask  out  2  active-high byte disable; bit0 = low byte, bit1 = high byte.
- prog_we  out  1  write request.
- prog_rdy  in  1  one-cycle acknowledge from the SDRAM controller.
- busy  out  1  ioctl_download OR hold register valid OR FIFO not empty.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: prog_addr=0, prog_data=0, prog_mask=2'b11, prog_we=0, busy=0, overflow=0. Reset also empties the FIFO and clears the hold register.
- Reset mid-operation discards every pending byte and word. No SDRAM write completes after rst rises.
- Byte accept: a byte is accepted only on the rising edge of ioctl_wr (ioctl_wr=1 while registered previous value=0). Extra high cycles on the same strobe are ignored.
- Hold register contents: word address, 16-bit data, 2-bit valid.
- Accepted byte handling:
  - If hold is valid and its word address differs from ioctl_addr[AW:1], the hold is pushed to the FIFO as a partial word (mask = ~valid) in the same cycle the new byte is loaded.
  - Otherwise the byte merges into its lane: ioctl_addr[0] selects the lane; that valid bit is set.
- Complete word: when both valid bits are set, the hold is pushed on the next clock (mask 2'b00) and the hold is cleared.
- Download start (rising edge of ioctl_download): clears the hold register and overflow. The FIFO is not flushed; older words keep draining.
- Download end (falling edge of ioctl_download): a valid partial hold is pushed with its mask on the following cycle.
- Push priority: when a complete-push and a new accept (or end-flush) coincide, the push is served first. The new byte then becomes the sole valid lane of a fresh hold.
- FIFO full: a push is dropped (FIFO contents unchanged) and overflow is set. overflow stays set until the next download start or reset.
- Write FSM states:
  - IDLE: if FIFO not empty, drive prog_addr/prog_data/prog_mask from the FIFO head, set prog_we=1, go to REQ.
  - REQ: hold all outputs stable. On prog_rdy=1, pop the FIFO, set prog_we=0, go to GAP.
  - GAP: one cycle with prog_we=0, then IDLE.
  - prog_rdy received outside REQ is ignored.
- Latency: with an empty FIFO and IDLE state, prog_we rises 3 clk_sys cycles after the accept edge of the completing byte.
- Throughput: one word per 3 cycles plus the controller's ready latency.
- Address wrap: the word address is truncated to AW bits; no special handling at the top of the address space.

Optional Feature:
- Macro: IOCTL_PACKER_CHECKSUM_EN.
- Defined: adds output port checksum (16 bits). It is cleared on download start and reset. Each accepted byte (including bytes later dropped on overflow) adds zero-extended ioctl_dout modulo 2^16. The value is valid once busy falls.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bytes 0x11@0, 0x22@1, each with ioctl_wr high 2 cycles -> exactly one write: prog_addr=0, prog_data=0x2211, prog_mask=2'b00.
- Bytes 0xAA@5, then 0xBB@8 -> write addr 2, data[15:8]=0xAA, mask 2'b01; then on download end, write addr 4, data[7:0]=0xBB, mask 2'b10.
- prog_rdy held low while 6 complete words arrive (FIFO_AW=2) -> 4 writes retained, overflow=1, busy=1. Release prog_rdy -> 4 writes in order, then busy=0.
- rst asserted while in REQ with 3 words queued -> prog_we=0 immediately, no further writes, busy=0 after rst drops.
- Download of 256 bytes of value k (k=0..255) with checksum enabled -> 128 writes, checksum=0x7F80, busy falls after the last prog_rdy.

Source files
------------

// File: rtl/ioctl_sdram_packer_if.sv
// Byte-download stream and SDRAM programming-port signals of ioctl_sdram_packer.
// slave = the packer; master = download source plus SDRAM controller side.
interface ioctl_sdram_packer_if #(
   parameter int AW = 24
);
   logic          ioctl_download;
   logic          ioctl_wr;
   logic [AW:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic [AW-1:0] prog_addr;
   logic [15:0]   prog_data;
   logic [1:0]    prog_mask;
   logic          prog_we;
   logic          prog_rdy;
   logic          busy;
   logic          overflow;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, prog_rdy,
      input  prog_addr, prog_data, prog_mask, prog_we, busy, overflow
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, prog_rdy,
      output prog_addr, prog_data, prog_mask, prog_we, busy, overflow
   );
endinterface

// File: rtl/ioctl_sdram_packer.sv
// Packs ioctl download bytes into masked 16-bit SDRAM words, queues them and writes them out.
// Optional checksum output port enabled by `define IOCTL_PACKER_CHECKSUM_EN.
module ioctl_sdram_packer #(
   parameter int FIFO_AW = 2,
   parameter int AW      = 24
) (
   input  logic                clk_sys,
   input  logic                rst,
   ioctl_sdram_packer_if.slave io
`ifdef IOCTL_PACKER_CHECKSUM_EN
   ,
   output logic [15:0]         checksum
`endif
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = AW + 18;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

   state_t state, state_nxt;

   logic          wr_q, dl_q;
   logic          accept, dl_rise, dl_fall;
   logic [AW-1:0] byte_waddr;

   logic [AW-1:0] hold_addr;
   logic [15:0]   hold_data;
   logic [1:0]    hold_vld;
   logic          hold_full, hold_part, addr_miss, push, fresh;

   logic [EW-1:0]    fifo_mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full, pop, load_out;
   logic             overflow_q;

   assign accept     = io.ioctl_wr & ~wr_q;
   assign dl_rise    = io.ioctl_download & ~dl_q;
   assign dl_fall    = ~io.ioctl_download & dl_q;
   assign byte_waddr = io.ioctl_addr[AW:1];

   assign hold_full = &hold_vld;
   assign hold_part = ^hold_vld;
   assign addr_miss = hold_part & (hold_addr != byte_waddr);
   // A download start discards the hold outright, so nothing is pushed in that cycle.
   assign push  = ~dl_rise & (hold_full | (hold_part & (dl_fall | (accept & addr_miss))));
   assign fresh = dl_rise | push | (hold_vld == 2'b00);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         wr_q <= 1'b0;
         dl_q <= 1'b0;
      end else begin
         wr_q <= io.ioctl_wr;
         dl_q <= io.ioctl_download;
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         hold_addr <= '0;
         hold_data <= '0;
         hold_vld  <= 2'b00;
      end else begin
         if (dl_rise || push) begin
            hold_vld <= 2'b00;
         end
         if (accept) begin
            if (fresh) begin
               hold_addr <= byte_waddr;
               hold_data <= io.ioctl_addr[0] ? {io.ioctl_dout, 8'h00} : {8'h00, io.ioctl_dout};
               hold_vld  <= io.ioctl_addr[0] ? 2'b10 : 2'b01;
            end else begin
               if (io.ioctl_addr[0]) begin
                  hold_data[15:8] <= io.ioctl_dout;
               end else begin
                  hold_data[7:0] <= io.ioctl_dout;
               end
               hold_vld[io.ioctl_addr[0]] <= 1'b1;
            end
         end
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

   always_ff @(posedge clk_sys) begin
      if (push && !fifo_full) begin
         fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {hold_addr, hold_data, ~hold_vld};
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            if (fifo_full) begin
               overflow_q <= 1'b1;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (dl_rise) begin
            overflow_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_out  = 1'b0;
      pop       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               load_out  = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (io.prog_rdy) begin
               pop       = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the FIFO head and stay frozen for the whole request.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         io.prog_addr <= '0;
         io.prog_data <= '0;
         io.prog_mask <= 2'b11;
         io.prog_we   <= 1'b0;
      end else begin
         if (load_out) begin
            {io.prog_addr, io.prog_data, io.prog_mask} <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
         end
         io.prog_we <= (state_nxt == S_REQ);
      end
   end

   assign io.busy     = io.ioctl_download | (|hold_vld) | ~fifo_empty;
   assign io.overflow = overflow_q;

`ifdef IOCTL_PACKER_CHECKSUM_EN
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         checksum <= '0;
      end else if (dl_rise) begin
         checksum <= accept ? {8'h00, io.ioctl_dout} : 16'h0000;
      end else if (accept) begin
         checksum <= checksum + {8'h00, io.ioctl_dout};
      end
   end
`endif
endmodule

// File: tb/tb_ioctl_sdram_packer.sv
// Bench for ioctl_sdram_packer: directed scenarios plus random downloads against a word-grouping model.
`timescale 1ns/1ps
module tb_ioctl_sdram_packer;
   typedef struct packed { logic [23:0] addr; logic [15:0] data; logic [1:0] mask; } wr_t;
   typedef struct packed { logic [24:0] addr; logic [7:0] data; } byte_t;

   logic clk_sys = 1'b0;
   logic rst     = 1'b1;
   always #5 clk_sys = ~clk_sys;

   ioctl_sdram_packer_if #(.AW(24)) io ();
`ifdef IOCTL_PACKER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   ioctl_sdram_packer #(.FIFO_AW(2), .AW(24)) dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .io      (io)
`ifdef IOCTL_PACKER_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   int    total = 0;
   int    bad   = 0;
   wr_t   got_q[$];
   wr_t   exp_q[$];
   byte_t bq[$];
   bit    rdy_en  = 1'b1;
   int    rdy_max = 1;
   int    rdy_wait = 0;

   // SDRAM controller model: acknowledges each request after a random delay and logs it.
   initial begin
      wr_t w;
      io.prog_rdy = 1'b0;
      forever begin
         @(negedge clk_sys);
         io.prog_rdy = 1'b0;
         if (!rst && rdy_en && io.prog_we) begin
            if (rdy_wait > 0) begin
               rdy_wait--;
            end else begin
               w.addr = io.prog_addr;
               w.data = io.prog_data;
               w.mask = io.prog_mask;
               got_q.push_back(w);
               io.prog_rdy = 1'b1;
               rdy_wait = $urandom_range(0, rdy_max);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic start_download();
      io.ioctl_download = 1'b1;
      bq.delete();
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic end_download();
      io.ioctl_download = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hi, input int lo);
      byte_t b;
      b.addr = a;
      b.data = d;
      bq.push_back(b);
      io.ioctl_addr = a;
      io.ioctl_dout = d;
      io.ioctl_wr   = 1'b1;
      repeat (hi) @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      repeat (lo) @(negedge clk_sys);
   endtask

   task automatic wait_writes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_sys);
         #1;
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Reference: bytes group into a word while they share a word address and the word is not full.
   task automatic model_expected();
      logic [23:0] wa;
      logic [15:0] wd;
      logic [1:0]  lanes;
      wr_t         w;
      wa = '0;
      wd = '0;
      lanes = 2'b00;
      foreach (bq[i]) begin
         if (lanes != 2'b00 && (lanes == 2'b11 || bq[i].addr[24:1] != wa)) begin
            w.addr = wa; w.data = wd; w.mask = ~lanes;
            exp_q.push_back(w);
            lanes = 2'b00;
            wd = '0;
         end
         wa = bq[i].addr[24:1];
         if (bq[i].addr[0]) begin
            wd[15:8] = bq[i].data;
            lanes[1] = 1'b1;
         end else begin
            wd[7:0]  = bq[i].data;
            lanes[0] = 1'b1;
         end
      end
      if (lanes != 2'b00) begin
         w.addr = wa; w.data = wd; w.mask = ~lanes;
         exp_q.push_back(w);
      end
   endtask

   task automatic test_reset();
      #1;
      total++; if (io.prog_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", io.prog_we); end
      repeat (3) @(negedge clk_sys);
      rst = 1'b0;
      @(negedge clk_sys);
      #1;
      total++; if (io.prog_addr !== 24'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", io.prog_addr); end
      total++; if (io.prog_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0", io.prog_data); end
      total++; if (io.prog_mask !== 2'b11) begin bad++; $display("FAIL reset_mask: got %b want 11", io.prog_mask); end
      total++; if (io.prog_we !== 1'b0) begin bad++; $display("FAIL reset_we_after: got %b want 0", io.prog_we); end
      total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", io.busy); end
      total++; if (io.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", io.overflow); end
   endtask

   task automatic test_pair();
      got_q.delete();
      rdy_max = 0;
      start_download();
      send_byte(25'd0, 8'h11, 2, 3);
      io.ioctl_addr = 25'd1;
      io.ioctl_dout = 8'h22;
      io.ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      total++; if (io.prog_we !== 1'b0) begin bad++; $display("FAIL pair_latency_early: got we=%b want 0", io.prog_we); end
      @(negedge clk_sys);
      total++; if (io.prog_we !== 1'b1) begin bad++; $display("FAIL pair_latency: got we=%b want 1", io.prog_we); end
      repeat (6) @(negedge clk_sys);
      end_download();
      repeat (6) @(negedge clk_sys);
      total++;
      if (got_q.size() !== 1) begin
         bad++; $display("FAIL pair_count: got %0d writes want 1", got_q.size());
      end else if (got_q[0].addr !== 24'd0 || got_q[0].data !== 16'h2211 || got_q[0].mask !== 2'b00) begin
         bad++; $display("FAIL pair_word: got addr=%h data=%h mask=%b want 0/2211/00",
                         got_q[0].addr, got_q[0].data, got_q[0].mask);
      end
   endtask

   task automatic test_partial();
      got_q.delete();
      rdy_max = 1;
      start_download();
      send_byte(25'd5, 8'hAA, 1, 3);
      send_byte(25'd8, 8'hBB, 1, 3);
      repeat (8) @(negedge clk_sys);
      total++;
      if (got_q.size() !== 1) begin
         bad++; $display("FAIL partial_first_count: got %0d writes want 1", got_q.size());
      end else if (got_q[0].addr !== 24'd2 || got_q[0].data[15:8] !== 8'hAA || got_q[0].mask !== 2'b01) begin
         bad++; $display("FAIL partial_first: got addr=%h data=%h mask=%b want 2/AA--/01",
                         got_q[0].addr, got_q[0].data, got_q[0].mask);
      end
      total++; if (io.busy !== 1'b1) begin bad++; $display("FAIL partial_busy_hold: got %b want 1", io.busy); end
      end_download();
      repeat (8) @(negedge clk_sys);
      total++;
      if (got_q.size() !== 2) begin
         bad++; $display("FAIL partial_end_count: got %0d writes want 2", got_q.size());
      end else if (got_q[1].addr !== 24'd4 || got_q[1].data[7:0] !== 8'hBB || got_q[1].mask !== 2'b10) begin
         bad++; $display("FAIL partial_end: got addr=%h data=%h mask=%b want 4/--BB/10",
                         got_q[1].addr, got_q[1].data, got_q[1].mask);
      end
      total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL partial_busy_end: got %b want 0", io.busy); end
   endtask

   task automatic test_overflow();
      bit ok;
      got_q.delete();
      exp_q.delete();
      rdy_en  = 1'b0;
      rdy_max = 1;
      start_download();
      for (int i = 0; i < 12; i++) send_byte(25'(12'h200 + i), 8'($urandom), 1, 2);
      end_download();
      repeat (4) @(negedge clk_sys);
      model_expected();
      total++; if (io.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", io.overflow); end
      total++; if (io.busy !== 1'b1) begin bad++; $display("FAIL ovf_busy: got %b want 1", io.busy); end
      total++; if (io.prog_we !== 1'b1) begin bad++; $display("FAIL ovf_we_waiting: got %b want 1", io.prog_we); end
      rdy_en = 1'b1;
      wait_writes(4, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL ovf_drain_timeout: got %0d writes want 4", got_q.size()); end
      repeat (20) @(negedge clk_sys);
      total++; if (got_q.size() !== 4) begin bad++; $display("FAIL ovf_count: got %0d writes want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL ovf_word[%0d]: got %h/%h/%b want %h/%h/%b", i, got_q[i].addr, got_q[i].data,
                            got_q[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
         end
      end
      total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_drained: got %b want 0", io.busy); end
      total++; if (io.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", io.overflow); end
      start_download();
      total++; if (io.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: got %b want 0", io.overflow); end
      end_download();
   endtask

   task automatic test_reset_mid();
      bit seen;
      got_q.delete();
      rdy_en = 1'b0;
      start_download();
      for (int i = 0; i < 6; i++) send_byte(25'(12'h300 + i), 8'($urandom), 1, 2);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_sys);
         seen = io.prog_we;
      end
      total++; if (!seen) begin bad++; $display("FAIL rstmid_req: got we=0 want 1 before reset"); end
      io.ioctl_download = 1'b0;
      rst = 1'b1;
      #1;
      total++; if (io.prog_we !== 1'b0) begin bad++; $display("FAIL rstmid_we: got %b want 0", io.prog_we); end
      repeat (3) @(negedge clk_sys);
      rst = 1'b0;
      rdy_en = 1'b1;
      @(negedge clk_sys);
      #1;
      total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", io.busy); end
      repeat (30) @(negedge clk_sys);
      total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rstmid_writes: got %0d writes want 0", got_q.size()); end
   endtask

   task automatic test_random();
      bit          ok;
      logic [24:0] a;
      int          sum;
      int          n;
      for (int d = 0; d < 4; d++) begin
         got_q.delete();
         exp_q.delete();
         rdy_max = 1;
         sum = 0;
         start_download();
         a = 25'($urandom_range(0, 63));
         for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            sum += v;
            send_byte(a, v, $urandom_range(1, 3), $urandom_range(3, 6));
            if ($urandom_range(0, 3) == 0) a = 25'($urandom_range(0, 2047));
            else a = a + 25'd1;
         end
         end_download();
         model_expected();
         wait_writes(exp_q.size(), 2000, ok);
         repeat (10) @(negedge clk_sys);
         n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
         total++;
         if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand_count[%0d]: got %0d writes want %0d", d, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].mask !== exp_q[i].mask ||
                (!exp_q[i].mask[0] && got_q[i].data[7:0] !== exp_q[i].data[7:0]) ||
                (!exp_q[i].mask[1] && got_q[i].data[15:8] !== exp_q[i].data[15:8])) begin
               bad++; $display("FAIL rand_word[%0d.%0d]: got %h/%h/%b want %h/%h/%b", d, i, got_q[i].addr,
                               got_q[i].data, got_q[i].mask, exp_q[i].addr, exp_q[i].data, exp_q[i].mask);
            end
         end
         total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL rand_busy[%0d]: got %b want 0", d, io.busy); end
         total++; if (io.overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow[%0d]: got %b want 0", d, io.overflow); end
`ifdef IOCTL_PACKER_CHECKSUM_EN
         total++;
         if (checksum !== 16'(sum)) begin
            bad++; $display("FAIL rand_checksum[%0d]: got %h want %h", d, checksum, 16'(sum));
         end
`endif
      end
   endtask

   task automatic test_full_download();
      bit ok;
      int errs;
      got_q.delete();
      rdy_en  = 1'b1;
      rdy_max = 1;
      start_download();
      for (int k = 0; k < 254; k++) send_byte(25'(k), 8'(k), 1, 3);
      wait_writes(127, 500, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_drain127: got %0d writes want 127", got_q.size()); end
      rdy_en = 1'b0;
      send_byte(25'd254, 8'd254, 1, 3);
      send_byte(25'd255, 8'd255, 1, 3);
      end_download();
      repeat (4) @(negedge clk_sys);
      total++; if (io.busy !== 1'b1) begin bad++; $display("FAIL full_busy_pending: got %b want 1", io.busy); end
      rdy_en = 1'b1;
      wait_writes(128, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_drain128: got %0d writes want 128", got_q.size()); end
      total++; if (io.busy !== 1'b1) begin bad++; $display("FAIL full_busy_at_last_rdy: got %b want 1", io.busy); end
      @(negedge clk_sys);
      #1;
      total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL full_busy_after: got %b want 0", io.busy); end
      repeat (10) @(negedge clk_sys);
      total++; if (got_q.size() !== 128) begin bad++; $display("FAIL full_count: got %0d writes want 128", got_q.size()); end
      errs = 0;
      for (int i = 0; i < 128 && i < got_q.size(); i++) begin
         logic [15:0] want;
         want = {8'(2 * i + 1), 8'(2 * i)};
         if (got_q[i].addr !== 24'(i) || got_q[i].data !== want || got_q[i].mask !== 2'b00) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL full_words: got %0d wrong words want 0", errs); end
`ifdef IOCTL_PACKER_CHECKSUM_EN
      total++; if (checksum !== 16'h7F80) begin bad++; $display("FAIL full_checksum: got %h want 7f80", checksum); end
`endif
   endtask

   initial begin
      io.ioctl_download = 1'b0;
      io.ioctl_wr       = 1'b0;
      io.ioctl_addr     = '0;
      io.ioctl_dout     = '0;
      test_reset();
      test_pair();
      test_partial();
      test_overflow();
      test_reset_mid();
      test_random();
      test_full_download();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
